icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Direct-mapped instruction cache that implements the responder end of the datapath instruction-fetch request protocol.
- It answers the datapath's imemREN/imemaddr requests with ihit/imemload.
- On a miss, it issues a single-word fill request to the memory controller and holds ihit low until the fill completes, which stalls the pipeline.
- It sits between the datapath and the memory controller's instruction port.

Parameters:
- NFRAMES, 16, number of cache frames; must be a power of 2, at least 2. One 32-bit word per frame.
- IDX_W, $clog2(NFRAMES), index width. Derived; do not override.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  datapath instruction read request.
- imemaddr  input  32  datapath fetch address. Byte address, word aligned.
- ihit  output  1  request satisfied this cycle; imemload is valid.
- imemload  output  32  instruction word returned to the datapath.
- iREN  output  1  fill read request to the memory controller.
- iaddr  output  32  fill address to the memory controller.
- iwait  input  1  memory busy; the fill word is not yet valid.
- iload  input  32  fill data from the memory controller.

Behaviour:
- One clock, CLK; reset nRST is asynchronous and active-low.
- Address split:
  - byte offset = imemaddr[1:0], ignored;
  - index = imemaddr[IDX_W+1:2];
  - tag = imemaddr[31:IDX_W+2].
- Per-frame storage: valid bit, tag, 32-bit data.
- hit = imemREN && valid[index] && (tag_store[index] == tag). This is combinational on the current imemaddr.
- FSM states: IDLE, FILL.
- IDLE:
  - ihit = hit; imemload = data[index] if hit, else 32'h0.
  - iREN = 0, iaddr = 32'h0.
  - If imemREN && !hit: latch miss_addr <= {imemaddr[31:2],2'b00}, then go to FILL.
- FILL:
  - ihit = 0, imemload = 32'h0.
  - iREN = 1, iaddr = miss_addr.
  - If iwait = 1: stay in FILL.
  - If iwait = 0 (the same cycle, the fill word is on iload): write frame[miss_addr index] with valid = 1, tag = miss_addr tag, data = iload, then go to IDLE.
- Latency:
  - Hit: 0 cycles, ihit in the same cycle as the request.
  - Miss with N iwait-high cycles: ihit rises N+2 cycles after the request first appears (1 IDLE detect cycle, N+1 FILL cycles, then the hit in IDLE).
- The fill always completes once started, even if imemREN drops or imemaddr changes during FILL. The frame is written with the latched miss_addr, never the live imemaddr.
- After a fill, re-evaluation in IDLE uses the current imemaddr. A changed address simply hits or misses normally.
- A fill replaces the existing frame unconditionally. There are no dirty bits; instruction memory is read-only from this side.
- When imemREN = 0 in IDLE: no state change, ihit = 0, imemload = 32'h0.
- Reset, including mid-FILL:
  - all valid bits = 0, state = IDLE, miss_addr = 0;
  - ihit = 0, imemload = 0, iREN = 0, iaddr = 0.
  - Tag/data contents are don't-care, but the bench must never see them while valid = 0.
- Index aliasing: addresses differing only in tag map to the same frame. A later fill evicts the earlier one.

Test Plan:
- Cold miss, then hit:
  - Stimulus: after reset, imemREN = 1, imemaddr = 32'h0000_0040; memory holds iwait = 1 for 2 cycles, then iwait = 0 with iload = 32'h2001_0005.
  - Required: iREN = 1 with iaddr = 32'h40 for 3 cycles; ihit = 1 with imemload = 32'h2001_0005 exactly 4 cycles after the request; iREN = 0 thereafter.
- Zero-wait fill:
  - Stimulus: imemaddr = 32'h4, iwait = 0 throughout, iload = 32'hDEAD_BEEF.
  - Required: ihit at cycle 2. A repeat access to 32'h4 hits in cycle 0 with iREN held 0.
- Aliasing eviction (NFRAMES = 16):
  - Stimulus: fill 32'h0000_0008 (data A), then 32'h0000_0048 (data B, same index), then re-request 32'h8.
  - Required: the 32'h8 re-request misses and iREN reasserts with iaddr = 32'h8.
- Request withdrawn mid-fill:
  - Stimulus: miss on 32'h10, then drop imemREN during FILL while iwait = 1.
  - Required: FILL completes, and the frame is written with tag/data of 32'h10. A later request to 32'h10 hits with no iREN.
- Reset mid-fill:
  - Stimulus: assert nRST = 0 asynchronously while in FILL.
  - Required: iREN, ihit and imemload drop to 0 immediately, without waiting for CLK. After release, a request to the previously filled address misses.
- Unaligned low bits:
  - Stimulus: imemaddr = 32'h0000_0043 after 32'h40 is filled.
  - Required: hit, returning 32'h40's data.

Source files
------------

// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped instruction cache, datapath fetch responder
module icache_responder #(
    parameter int NFRAMES = 16,
    localparam int IDX_W  = $clog2(NFRAMES)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t             state;
    logic [NFRAMES-1:0] valid;
    logic [TAG_W-1:0]   tag_store  [NFRAMES];
    logic [31:0]        data_store [NFRAMES];

    // Word address of the outstanding miss; byte offset is always zero so it is not stored.
    logic [29:0]        miss_word;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   miss_idx;
    logic [TAG_W-1:0]   miss_tag;
    logic               hit;
    logic               fill_done;
    logic               unused_offset;

    assign req_idx       = imemaddr[IDX_W+1:2];
    assign req_tag       = imemaddr[31:IDX_W+2];
    assign miss_idx      = miss_word[IDX_W-1:0];
    assign miss_tag      = miss_word[29:IDX_W];
    assign unused_offset = ^imemaddr[1:0];

    // Lookup is purely combinational so a hit answers in the request cycle.
    assign hit       = imemREN && valid[req_idx] && (tag_store[req_idx] == req_tag);
    assign fill_done = (state == FILL) && !iwait;

    // Control state: FSM, valid bits and latched miss address; reset clears them asynchronously.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            valid     <= '0;
            miss_word <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (imemREN && !hit) begin
                        miss_word <= imemaddr[31:2];
                        state     <= FILL;
                    end
                end
                FILL: begin
                    // Fill completes from the latched address regardless of the live request.
                    if (!iwait) begin
                        valid[miss_idx] <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays need no reset; they are only observed through a set valid bit.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_store[miss_idx]  <= miss_tag;
            data_store[miss_idx] <= iload;
        end
    end

    // Outputs follow the state directly so an asynchronous reset drops them at once.
    always_comb begin
        ihit     = 1'b0;
        imemload = 32'h0;
        iREN     = 1'b0;
        iaddr    = 32'h0;
        if (state == IDLE) begin
            ihit = hit;
            if (hit) begin
                imemload = data_store[req_idx];
            end
        end else begin
            iREN  = 1'b1;
            iaddr = {miss_word, 2'b00};
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - directed self-checking bench for icache_responder
module tb_icache_responder;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int n_checks;
    int n_fail;

    icache_responder #(.NFRAMES(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge, where new inputs are driven.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs, well clear of any edge.
    task automatic look();
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iwait    = 1'b1;
        iload    = 32'h0;

        // Reset state
        cyc(); cyc();
        look();
        check("rst_ihit", {31'h0, ihit}, 32'h0);
        check("rst_imemload", imemload, 32'h0);
        check("rst_iREN", {31'h0, iREN}, 32'h0);
        check("rst_iaddr", iaddr, 32'h0);
        cyc();
        nRST = 1'b1;

        // Cold miss on 0x40 with two wait cycles
        cyc();
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
        look();
        check("cold_c0_ihit", {31'h0, ihit}, 32'h0);
        check("cold_c0_iREN", {31'h0, iREN}, 32'h0);
        cyc();
        look();
        check("cold_c1_iREN", {31'h0, iREN}, 32'h1);
        check("cold_c1_iaddr", iaddr, 32'h40);
        check("cold_c1_ihit", {31'h0, ihit}, 32'h0);
        cyc();
        look();
        check("cold_c2_iREN", {31'h0, iREN}, 32'h1);
        check("cold_c2_iaddr", iaddr, 32'h40);
        cyc();
        iwait = 1'b0; iload = 32'h2001_0005;
        look();
        check("cold_c3_iREN", {31'h0, iREN}, 32'h1);
        check("cold_c3_iaddr", iaddr, 32'h40);
        check("cold_c3_ihit", {31'h0, ihit}, 32'h0);
        cyc();
        iwait = 1'b1; iload = 32'h0;
        look();
        check("cold_c4_ihit", {31'h0, ihit}, 32'h1);
        check("cold_c4_imemload", imemload, 32'h2001_0005);
        check("cold_c4_iREN", {31'h0, iREN}, 32'h0);

        // Unaligned low bits hit the same word
        cyc();
        imemaddr = 32'h43;
        look();
        check("unal_ihit", {31'h0, ihit}, 32'h1);
        check("unal_imemload", imemload, 32'h2001_0005);
        check("unal_iREN", {31'h0, iREN}, 32'h0);

        // Zero-wait fill of 0x4
        cyc();
        imemaddr = 32'h4; iwait = 1'b0; iload = 32'hDEAD_BEEF;
        look();
        check("zw_c0_ihit", {31'h0, ihit}, 32'h0);
        cyc();
        look();
        check("zw_c1_iREN", {31'h0, iREN}, 32'h1);
        check("zw_c1_iaddr", iaddr, 32'h4);
        cyc();
        iload = 32'h0;
        look();
        check("zw_c2_ihit", {31'h0, ihit}, 32'h1);
        check("zw_c2_imemload", imemload, 32'hDEAD_BEEF);
        cyc();
        imemREN = 1'b0;
        look();
        check("idle_noren_ihit", {31'h0, ihit}, 32'h0);
        check("idle_noren_imemload", imemload, 32'h0);
        check("idle_noren_iREN", {31'h0, iREN}, 32'h0);
        cyc();
        imemREN = 1'b1;
        look();
        check("zw_repeat_ihit", {31'h0, ihit}, 32'h1);
        check("zw_repeat_imemload", imemload, 32'hDEAD_BEEF);
        check("zw_repeat_iREN", {31'h0, iREN}, 32'h0);

        // Aliasing: 0x8 and 0x48 share index 2
        cyc();
        imemaddr = 32'h8; iload = 32'hAAAA_0001;
        cyc();
        cyc();
        look();
        check("alias_A_ihit", {31'h0, ihit}, 32'h1);
        check("alias_A_imemload", imemload, 32'hAAAA_0001);
        cyc();
        imemaddr = 32'h48; iload = 32'hBBBB_0002;
        look();
        check("alias_B_miss", {31'h0, ihit}, 32'h0);
        cyc();
        cyc();
        look();
        check("alias_B_ihit", {31'h0, ihit}, 32'h1);
        check("alias_B_imemload", imemload, 32'hBBBB_0002);
        cyc();
        imemaddr = 32'h8; iload = 32'hAAAA_0001;
        look();
        check("alias_re8_ihit", {31'h0, ihit}, 32'h0);
        cyc();
        look();
        check("alias_re8_iREN", {31'h0, iREN}, 32'h1);
        check("alias_re8_iaddr", iaddr, 32'h8);
        cyc();

        // Request withdrawn mid-fill on 0x10
        imemaddr = 32'h10; iwait = 1'b1; iload = 32'h0;
        look();
        check("wd_c0_ihit", {31'h0, ihit}, 32'h0);
        cyc();
        imemREN = 1'b0; imemaddr = 32'h4;
        look();
        check("wd_c1_iREN", {31'h0, iREN}, 32'h1);
        check("wd_c1_iaddr", iaddr, 32'h10);
        cyc();
        iwait = 1'b0; iload = 32'h1010_1010;
        look();
        check("wd_c2_iREN", {31'h0, iREN}, 32'h1);
        check("wd_c2_iaddr", iaddr, 32'h10);
        cyc();
        iwait = 1'b1; iload = 32'h0;
        look();
        check("wd_c3_iREN", {31'h0, iREN}, 32'h0);
        check("wd_c3_ihit", {31'h0, ihit}, 32'h0);
        cyc();
        imemREN = 1'b1; imemaddr = 32'h10;
        look();
        check("wd_hit_ihit", {31'h0, ihit}, 32'h1);
        check("wd_hit_imemload", imemload, 32'h1010_1010);
        check("wd_hit_iREN", {31'h0, iREN}, 32'h0);
        cyc();
        imemaddr = 32'h4;
        look();
        check("wd_other_ihit", {31'h0, ihit}, 32'h1);
        check("wd_other_imemload", imemload, 32'hDEAD_BEEF);

        // Reset asserted asynchronously during FILL of 0x80
        cyc();
        imemaddr = 32'h80; iwait = 1'b1;
        cyc();
        look();
        check("rmf_fill_iREN", {31'h0, iREN}, 32'h1);
        check("rmf_fill_iaddr", iaddr, 32'h80);
        imemaddr = 32'h4;
        #1;
        nRST = 1'b0;
        #1;
        check("rmf_async_iREN", {31'h0, iREN}, 32'h0);
        check("rmf_async_iaddr", iaddr, 32'h0);
        check("rmf_async_ihit", {31'h0, ihit}, 32'h0);
        check("rmf_async_imemload", imemload, 32'h0);
        cyc();
        nRST = 1'b1;
        look();
        check("rmf_post_miss_ihit", {31'h0, ihit}, 32'h0);
        check("rmf_post_miss_imemload", imemload, 32'h0);
        iwait = 1'b0; iload = 32'h1234_5678;
        cyc();
        look();
        check("rmf_refill_iREN", {31'h0, iREN}, 32'h1);
        check("rmf_refill_iaddr", iaddr, 32'h4);
        cyc();
        look();
        check("rmf_refill_ihit", {31'h0, ihit}, 32'h1);
        check("rmf_refill_imemload", imemload, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
